btn_debouncer: RTL and testbench

- Front end for a raw mechanical push-button: synchronises the pad input, debounces both press and release, and emits clean one-cycle event pulses.
- o_btn_posedge is the single-cycle press event consumed by the downstream button lock-out/activator logic.
- Also provides a debounced level, a release pulse and a one-shot long-press pulse (used for metronome tempo-hold functions).

---
 rtl/btn_pkg.sv | 33 +++
 rtl/btn_sync.sv | 35 +++
 rtl/btn_debouncer.sv | 165 ++++++++++++++++
 tb/tb_btn_debouncer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default timing constants and clog2 helper for the button front end
//
// Purpose : common definitions imported by btn_sync and btn_debouncer.
// Contents: btn_state_t (2-bit FSM encoding), default debounce/hold
//           cycle counts (50 MHz system clock), clog2 for counter widths.

package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long-press at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 50000000;

    // Number of bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchroniser for an asynchronous pad input
//
// Purpose : bring an asynchronous pad level into the i_clk domain.
// Ports   : i_clk     system clock
//           i_rst_n   synchronous active-low reset
//           i_async   raw asynchronous pad level
//           o_sync    synchronised level (two flops behind the pad)
// RESET_VALUE loads both flops on reset so that the idle pad level does
// not look like a transition when reset is released.

module btn_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - push-button synchroniser, press/release debouncer and event pulse generator
//
// Purpose : turn a bouncing mechanical button pad into a clean debounced
//           level plus single-cycle press, release and long-press events.
// Ports   : i_clk          system clock
//           i_rst_n        synchronous active-low reset
//           i_btn_raw      raw asynchronous button pad
//           o_btn_level    debounced pressed level (1 = pressed)
//           o_btn_posedge  one-cycle pulse on accepted press
//           o_btn_negedge  one-cycle pulse on accepted release
//           o_btn_hold     one-cycle pulse once per press after HOLD_CYCLES

module btn_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_btn_posedge,
    output logic o_btn_negedge,
    output logic o_btn_hold
);

    localparam int DEB_W  = clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic              ACT_LOW  = (ACTIVE_LOW != 0);

    logic              w_sync;
    logic              w_pressed_s;

    btn_state_t        r_state;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_level;
    logic              r_posedge;
    logic              r_negedge;
    logic              r_hold;

    btn_state_t        w_state_nxt;
    logic [DEB_W-1:0]  w_deb_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              w_level_nxt;
    logic              w_posedge_nxt;
    logic              w_negedge_nxt;
    logic              w_hold_nxt;

    // Reset value is the idle (released) pad level for either polarity.
    btn_sync #(
        .RESET_VALUE (ACT_LOW)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_btn_raw),
        .o_sync  (w_sync)
    );

    assign w_pressed_s = w_sync ^ ACT_LOW;
    assign w_hold_inc  = r_hold_cnt + HOLD_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= RELEASED;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_posedge  <= 1'b0;
            r_negedge  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_level    <= w_level_nxt;
            r_posedge  <= w_posedge_nxt;
            r_negedge  <= w_negedge_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_deb_nxt      = r_deb_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_level_nxt    = r_level;
        w_posedge_nxt  = 1'b0;
        w_negedge_nxt  = 1'b0;
        w_hold_nxt     = 1'b0;

        case (r_state)
            RELEASED: begin
                if (w_pressed_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_deb_nxt   = DEB_W'(1);
                end else begin
                    w_deb_nxt   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!w_pressed_s) begin
                    w_state_nxt = RELEASED;
                    w_deb_nxt   = '0;
                end else if (r_deb_cnt == DEB_MAX) begin
                    w_state_nxt    = PRESSED;
                    w_posedge_nxt  = 1'b1;
                    w_level_nxt    = 1'b1;
                    w_deb_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_deb_nxt   = r_deb_cnt + DEB_W'(1);
                end
            end

            PRESSED: begin
                // Saturating count; the pulse marks only the step onto
                // HOLD_MAX, so it cannot repeat within one press.
                if (r_hold_cnt != HOLD_MAX) begin
                    w_hold_cnt_nxt = w_hold_inc;
                    w_hold_nxt     = (w_hold_inc == HOLD_MAX);
                end
                if (!w_pressed_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_deb_nxt   = DEB_W'(1);
                end
            end

            RELEASE_WAIT: begin
                // hold_cnt is frozen here and survives a bounce back to
                // PRESSED, keeping the long-press one-shot per press.
                if (w_pressed_s) begin
                    w_state_nxt = PRESSED;
                    w_deb_nxt   = '0;
                end else if (r_deb_cnt == DEB_MAX) begin
                    w_state_nxt    = RELEASED;
                    w_negedge_nxt  = 1'b1;
                    w_level_nxt    = 1'b0;
                    w_deb_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_deb_nxt   = r_deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                w_state_nxt = RELEASED;
                w_deb_nxt   = '0;
            end
        endcase
    end

    assign o_btn_level   = r_level;
    assign o_btn_posedge = r_posedge;
    assign o_btn_negedge = r_negedge;
    assign o_btn_hold    = r_hold;

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - scoreboard bench for btn_debouncer (active-low and active-high instances)

module tb_btn_debouncer;

    localparam int KIND_POS  = 0;
    localparam int KIND_NEG  = 1;
    localparam int KIND_HOLD = 2;

    typedef struct {
        int dut;
        int kind;
        int cyc;
    } evt_t;

    logic clk;
    logic rst_a, raw_a, a_lvl, a_pos, a_neg, a_hold;
    logic rst_b, raw_b, b_lvl, b_pos, b_neg, b_hold;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    evt_t exp_q[$];

    btn_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .ACTIVE_LOW      (1)
    ) dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_a),
        .i_btn_raw     (raw_a),
        .o_btn_level   (a_lvl),
        .o_btn_posedge (a_pos),
        .o_btn_negedge (a_neg),
        .o_btn_hold    (a_hold)
    );

    btn_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .ACTIVE_LOW      (0)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_b),
        .i_btn_raw     (raw_b),
        .o_btn_level   (b_lvl),
        .o_btn_posedge (b_pos),
        .o_btn_negedge (b_neg),
        .o_btn_hold    (b_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int dut, input int kind, input int at_cyc);
        evt_t e;
        e.dut  = dut;
        e.kind = kind;
        e.cyc  = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        tests = tests + 1;
        if (act != exp_v) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor side: every pulse the DUT presents must match the next
    // expected event in dut, kind and cycle; level must agree with it.
    task automatic check_evt(input int dut, input int kind, input logic lvl);
        evt_t e;
        int   exp_lvl;
        tests = tests + 1;
        if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_event: got dut=%0d kind=%0d cyc=%0d expected none",
                     dut, kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != dut || e.kind != kind || e.cyc != cyc) begin
                fails = fails + 1;
                $display("FAIL event: got dut=%0d kind=%0d cyc=%0d expected dut=%0d kind=%0d cyc=%0d",
                         dut, kind, cyc, e.dut, e.kind, e.cyc);
            end
        end
        exp_lvl = (kind == KIND_NEG) ? 0 : 1;
        chk("event_level", int'(lvl), exp_lvl);
    endtask

    always @(negedge clk) begin
        if (a_pos)  check_evt(0, KIND_POS,  a_lvl);
        if (a_neg)  check_evt(0, KIND_NEG,  a_lvl);
        if (a_hold) check_evt(0, KIND_HOLD, a_lvl);
        if (b_pos)  check_evt(1, KIND_POS,  b_lvl);
        if (b_neg)  check_evt(1, KIND_NEG,  b_lvl);
        if (b_hold) check_evt(1, KIND_HOLD, b_lvl);
    end

    initial begin
        int t;
        rst_a = 1'b0;
        rst_b = 1'b0;
        raw_a = 1'b1;
        raw_b = 1'b0;
        step(3);
        chk("a_reset_outs", int'({a_lvl, a_pos, a_neg, a_hold}), 0);
        chk("b_reset_outs", int'({b_lvl, b_pos, b_neg, b_hold}), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(5);

        // Clean press held 40 cycles: press at +7, long-press at +27.
        raw_a = 1'b0;
        t = cyc;
        expect_evt(0, KIND_POS,  t + 7);
        expect_evt(0, KIND_HOLD, t + 27);
        step(6);
        chk("a_level_before_press", int'(a_lvl), 0);
        step(1);
        chk("a_level_at_press", int'(a_lvl), 1);
        step(33);
        raw_a = 1'b1;
        t = cyc;
        expect_evt(0, KIND_NEG, t + 7);
        step(6);
        chk("a_level_before_release", int'(a_lvl), 1);
        step(1);
        chk("a_level_at_release", int'(a_lvl), 0);
        step(10);

        // Press bounce: runs of 3 never reach the debounce count.
        for (int r = 0; r < 10; r++) begin
            raw_a = (r % 2 == 0) ? 1'b0 : 1'b1;
            step(3);
        end
        chk("a_level_after_bounce", int'(a_lvl), 0);
        raw_a = 1'b0;
        t = cyc;
        expect_evt(0, KIND_POS,  t + 7);
        expect_evt(0, KIND_HOLD, t + 27);
        step(30);

        // Release bounce after the long-press already fired.
        raw_a = 1'b1;
        step(2);
        raw_a = 1'b0;
        step(2);
        raw_a = 1'b1;
        t = cyc;
        expect_evt(0, KIND_NEG, t + 7);
        step(7);
        chk("a_level_after_rel_bounce", int'(a_lvl), 0);
        step(10);

        // Reset while in PRESS_WAIT, button kept pressed through it.
        raw_a = 1'b0;
        step(4);
        rst_a = 1'b0;
        step(1);
        chk("a_rst_presswait_outs", int'({a_lvl, a_pos, a_neg, a_hold}), 0);
        step(1);
        rst_a = 1'b1;
        t = cyc;
        expect_evt(0, KIND_POS, t + 7);
        step(7);
        chk("a_level_after_rst_press", int'(a_lvl), 1);
        step(3);

        // Reset while in PRESSED.
        rst_a = 1'b0;
        step(1);
        chk("a_rst_pressed_outs", int'({a_lvl, a_pos, a_neg, a_hold}), 0);
        step(1);
        rst_a = 1'b1;
        t = cyc;
        expect_evt(0, KIND_POS, t + 7);
        step(7);
        chk("a_level_after_rst2", int'(a_lvl), 1);
        step(3);
        raw_a = 1'b1;
        t = cyc;
        expect_evt(0, KIND_NEG, t + 7);
        step(12);

        // Active-high instance: idle raw=0 produced nothing so far.
        chk("b_level_idle", int'(b_lvl), 0);
        raw_b = 1'b1;
        t = cyc;
        expect_evt(1, KIND_POS, t + 7);
        step(6);
        chk("b_level_before_press", int'(b_lvl), 0);
        step(1);
        chk("b_level_at_press", int'(b_lvl), 1);
        step(10);
        raw_b = 1'b0;
        t = cyc;
        expect_evt(1, KIND_NEG, t + 7);
        step(12);

        chk("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
